fx2ieee_rr_scheduler: RTL and testbench

- Shares one combinational fixed-point to IEEE-style converter among N_REQ requesters.
- Each requester presents an integer part, a fraction part and a sign through a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and drives the granted operands onto the converter port.
- The converter result is registered together with the requester ID into a single output stage with valid/ready backpressure.

---
 rtl/fx2ieee_rr_scheduler.sv | 91 +++++++++
 tb/tb_fx2ieee_rr_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2ieee_rr_scheduler.sv
// Round-robin scheduler sharing one combinational fixed-point to IEEE converter
// among N_REQ requesters, with a single registered valid/ready output stage.
module fx2ieee_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int INT_LEN = 16,
    parameter int FRA_LEN = 16,
    parameter int MON_LEN = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*INT_LEN-1:0]   req_int,
    input  logic [N_REQ*FRA_LEN-1:0]   req_frac,
    input  logic [N_REQ-1:0]           req_sign,
    output logic [INT_LEN-1:0]         conv_int,
    output logic [FRA_LEN-1:0]         conv_frac,
    output logic                       conv_sign,
    input  logic [MON_LEN+8:0]         conv_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MON_LEN+8:0]         out_data,
    output logic [ID_W-1:0]            out_id
);

    localparam int unsigned NR = N_REQ;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gsel;
    logic [ID_W-1:0]  cand;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic             advance;

    assign advance = !out_valid || out_ready;

    // First asserted requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NR);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) begin
            grant[gsel] = 1'b1;
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign req_ready = grant & {N_REQ{advance & rst_n}};

    always_comb begin
        conv_int  = '0;
        conv_frac = '0;
        conv_sign = 1'b0;
        if (found) begin
            conv_int  = req_int[gsel*INT_LEN +: INT_LEN];
            conv_frac = req_frac[gsel*FRA_LEN +: FRA_LEN];
            conv_sign = req_sign[gsel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (advance) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= conv_result;
                out_id    <= gsel;
                rr_ptr    <= ID_W'((32'(gsel) + 1) % NR);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fx2ieee_rr_scheduler.sv
// Directed bench for fx2ieee_rr_scheduler using a stub converter that packs its
// operands into the result word (all-zero for a zero magnitude).
module tb_fx2ieee_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_int;
    logic [63:0] req_frac;
    logic [3:0]  req_sign;
    logic [15:0] conv_int;
    logic [15:0] conv_frac;
    logic        conv_sign;
    logic [31:0] conv_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_id;

    int pass_cnt;
    int total_cnt;

    fx2ieee_rr_scheduler #(
        .N_REQ  (4),
        .ID_W   (2),
        .INT_LEN(16),
        .FRA_LEN(16),
        .MON_LEN(23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_int    (req_int),
        .req_frac   (req_frac),
        .req_sign   (req_sign),
        .conv_int   (conv_int),
        .conv_frac  (conv_frac),
        .conv_sign  (conv_sign),
        .conv_result(conv_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] stub(input logic [15:0] i, input logic [15:0] f, input logic s);
        if (i == 16'd0 && f == 16'd0) return 32'd0;
        return {s, i[14:0], f};
    endfunction

    always_comb conv_result = stub(conv_int, conv_frac, conv_sign);

    function automatic logic [31:0] stream_exp(input int r);
        return stub(16'(10 + r), 16'(r * 256), logic'(r & 1));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] iv, input logic [15:0] fv, input logic s);
        req_int[i*16 +: 16]  = iv;
        req_frac[i*16 +: 16] = fv;
        req_sign[i]          = s;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_int   = '0;
        req_frac  = '0;
        req_sign  = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'd0) $display("FAIL reset_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++;
        if (out_id !== 2'd0) $display("FAIL reset_id got %0d want 0", out_id); else pass_cnt++;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else pass_cnt++;
        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        set_req(2, 16'd5, 16'd0, 1'b0);
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL single_ready got %b want 0100", req_ready); else pass_cnt++;
        total_cnt++;
        if (conv_int !== 16'd5 || conv_frac !== 16'd0 || conv_sign !== 1'b0)
            $display("FAIL single_conv got %h/%h/%b want 0005/0000/0", conv_int, conv_frac, conv_sign);
        else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) $display("FAIL single_out got v=%b id=%0d want v=1 id=2", out_valid, out_id); else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0005_0000) $display("FAIL single_data got %h want 00050000", out_data); else pass_cnt++;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000 || conv_int !== 16'd0) $display("FAIL idle_conv got ready=%b int=%h want 0000/0000", req_ready, conv_int); else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || out_id !== 2'd2 || out_data !== 32'h0005_0000)
            $display("FAIL drain got v=%b id=%0d d=%h want v=0 id=2 d=00050000", out_valid, out_id, out_data);
        else pass_cnt++;
    endtask

    // Pointer is 3 after test_single, so the rotation starts at requester 3.
    task automatic test_rr_stream;
        int seq [6] = '{3, 0, 1, 2, 3, 0};
        for (int r = 0; r < 4; r++) set_req(r, 16'(10 + r), 16'(r * 256), logic'(r & 1));
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total_cnt++;
            if (req_ready !== 4'(1 << seq[k])) $display("FAIL stream_ready[%0d] got %b want %b", k, req_ready, 4'(1 << seq[k])); else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_id !== 2'(seq[k]))
                $display("FAIL stream_out[%0d] got v=%b id=%0d want v=1 id=%0d", k, out_valid, out_id, seq[k]);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== stream_exp(seq[k])) $display("FAIL stream_data[%0d] got %h want %h", k, out_data, stream_exp(seq[k])); else pass_cnt++;
        end
    endtask

    // Holding id 0; pointer is 1.
    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if (req_ready !== 4'b0000) $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready); else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== stream_exp(0))
                $display("FAIL stall_hold[%0d] got v=%b id=%0d d=%h want v=1 id=0 d=%h", k, out_valid, out_id, out_data, stream_exp(0));
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL resume_ready got %b want 0010", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== stream_exp(1))
            $display("FAIL resume_out got v=%b id=%0d d=%h want v=1 id=1 d=%h", out_valid, out_id, out_data, stream_exp(1));
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL resume_drain got %b want 0", out_valid); else pass_cnt++;
    endtask

    // Pointer is 2: grant 3, idle, then 4'b0011 must pick 0.
    task automatic test_wrap_idle;
        req_valid = 4'b1000;
        #1;
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL wrap_ready3 got %b want 1000", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        total_cnt++;
        if (out_id !== 2'd3) $display("FAIL wrap_id3 got %0d want 3", out_id); else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL wrap_idle got %b want 0", out_valid); else pass_cnt++;
        req_valid = 4'b0011;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL wrap_ready0 got %b want 0001", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) $display("FAIL wrap_id0 got v=%b id=%0d want v=1 id=0", out_valid, out_id); else pass_cnt++;
        tick();
    endtask

    // Pointer is 1.
    task automatic test_zero;
        set_req(1, 16'd0, 16'd0, 1'b1);
        req_valid = 4'b0010;
        #1;
        total_cnt++;
        if (conv_sign !== 1'b1 || conv_int !== 16'd0) $display("FAIL zero_conv got s=%b int=%h want s=1 int=0000", conv_sign, conv_int); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 32'd0)
            $display("FAIL zero_out got v=%b id=%0d d=%h want v=1 id=1 d=00000000", out_valid, out_id, out_data);
        else pass_cnt++;
        tick();
    endtask

    // Pointer is 2; after the grant to 2 it would be 3, reset must return it to 0.
    task automatic test_async_reset;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) $display("FAIL pre_reset got v=%b id=%0d want v=1 id=2", out_valid, out_id); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_id !== 2'd0)
            $display("FAIL async_clear got v=%b id=%0d d=%h want v=0 id=0 d=00000000", out_valid, out_id, out_data);
        else pass_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL post_reset_ready got %b want 0010", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) $display("FAIL post_reset_id got v=%b id=%0d want v=1 id=1", out_valid, out_id); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single();
        test_rr_stream();
        test_backpressure();
        test_wrap_idle();
        test_zero();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
